// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the PLL reconfiguration sequencers:
// sequencer state encoding, divide limits, counter field widths and the
// divide-to-counter-field mapping used by pll_div_encoder and for reset values.
package pll_reconfig_pkg;

  localparam int DIV_W   = 8;
  localparam int FIELD_W = 6;

  localparam logic [DIV_W-1:0] DIV_MIN = 8'd1;
  localparam logic [DIV_W-1:0] DIV_MAX = 8'd126;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WAIT_RDY  = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    WAIT_LOCK = 3'd5,
    FINISH    = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic               no_count;
    logic               edge_bit;
    logic [FIELD_W-1:0] high_time;
    logic [FIELD_W-1:0] low_time;
  } div_fields_t;

  function automatic logic div_legal(input logic [DIV_W-1:0] d);
    return (d >= DIV_MIN) && (d <= DIV_MAX);
  endfunction

  // Divide 1 bypasses the counter; otherwise the high phase gets the smaller
  // half and the odd-divide edge bit absorbs the extra half period.
  function automatic div_fields_t encode_divide(input logic [DIV_W-1:0] d);
    div_fields_t f;
    if (d == 8'd1) begin
      f.no_count  = 1'b1;
      f.edge_bit  = 1'b0;
      f.high_time = 6'd1;
      f.low_time  = 6'd1;
    end else begin
      f.no_count  = 1'b0;
      f.edge_bit  = d[0];
      f.high_time = FIELD_W'(d >> 1'b1);
      f.low_time  = FIELD_W'(d - (d >> 1'b1));
    end
    return f;
  endfunction

endpackage

// File: rtl/pll_div_encoder.sv
// Combinational divide-to-counter-field mapping for one PLL output counter.
// Kept separate so CLKFBOUT/DIVCLK sequencers can reuse the same mapping.
module pll_div_encoder
  import pll_reconfig_pkg::*;
(
  input  logic [DIV_W-1:0]   divide,
  output logic [FIELD_W-1:0] high_time,
  output logic [FIELD_W-1:0] low_time,
  output logic               edge_bit,
  output logic               no_count,
  output logic               legal
);

  div_fields_t fields_s;

  // Map the requested divide onto counter fields and flag out-of-range values.
  always_comb begin
    fields_s  = encode_divide(divide);
    high_time = fields_s.high_time;
    low_time  = fields_s.low_time;
    edge_bit  = fields_s.edge_bit;
    no_count  = fields_s.no_count;
    legal     = div_legal(divide);
  end

endmodule

// File: rtl/pll_freq_sequencer.sv
// PLL CLKOUT0 frequency sequencer: accepts a divide request, validates it,
// hands counter fields to the DRP reconfiguration engine, waits for the
// engine to finish and for LOCKED to be stable, then reports completion.
// Optional lock/done watchdog: define PLL_SEQ_LOCK_TIMEOUT_EN.
module pll_freq_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int DIVIDE_RESET        = 20,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int LOCK_STABLE_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [DIV_W-1:0]   req_divide,
  output logic               req_ready,
  output logic [FIELD_W-1:0] clkout0_high_time,
  output logic [FIELD_W-1:0] clkout0_low_time,
  output logic               clkout0_edge,
  output logic               clkout0_no_count,
  output logic               start_reconfig,
  input  logic               reconfig_ready,
  input  logic               reconfig_done,
  input  logic               pll_locked,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [DIV_W-1:0]   cur_divide
);

  localparam int LOCK_CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam div_fields_t RESET_FIELDS = encode_divide(DIV_W'(DIVIDE_RESET));

  seq_state_t             state_r, state_s;
  logic [DIV_W-1:0]       div_r;
  logic [DIV_W-1:0]       cur_divide_r;
  div_fields_t            fields_r;
  div_fields_t            enc_fields_s;
  logic                   enc_legal_s;
  logic                   error_r, start_r, done_r, busy_r, ready_r;
  logic [LOCK_CNT_W-1:0]  lock_cnt_r, lock_cnt_s;
  logic                   accept_s, reject_s, load_fields_s, timeout_s;
  logic                   wd_expired_s;

  pll_div_encoder u_div_encoder (
    .divide    (div_r),
    .high_time (enc_fields_s.high_time),
    .low_time  (enc_fields_s.low_time),
    .edge_bit  (enc_fields_s.edge_bit),
    .no_count  (enc_fields_s.no_count),
    .legal     (enc_legal_s)
  );

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
  localparam int WD_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_r;

  // Watchdog: one shared count across WAIT_DONE and WAIT_LOCK, cleared elsewhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_r <= '0;
    end else if ((state_r == WAIT_DONE) || (state_r == WAIT_LOCK)) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  assign wd_expired_s = ((state_r == WAIT_DONE) || (state_r == WAIT_LOCK)) &&
                        (wd_cnt_r == WD_LAST);
`else
  logic timeout_unused_s;

  assign wd_expired_s     = 1'b0;
  assign timeout_unused_s = (LOCK_TIMEOUT_CYCLES > 0);
`endif

  // Next-state logic; engine progress wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_s       = state_r;
    lock_cnt_s    = '0;
    accept_s      = 1'b0;
    reject_s      = 1'b0;
    load_fields_s = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = CHECK;
        end else begin
          state_s  = IDLE;
        end
      end
      CHECK: begin
        if (enc_legal_s) begin
          load_fields_s = 1'b1;
          state_s       = WAIT_RDY;
        end else begin
          reject_s      = 1'b1;
          state_s       = IDLE;
        end
      end
      WAIT_RDY: begin
        if (reconfig_ready) begin
          state_s = START;
        end else begin
          state_s = WAIT_RDY;
        end
      end
      START: begin
        state_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (reconfig_done) begin
          state_s   = WAIT_LOCK;
        end else if (wd_expired_s) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = WAIT_DONE;
        end
      end
      WAIT_LOCK: begin
        if (pll_locked) begin
          lock_cnt_s = lock_cnt_r + LOCK_CNT_W'(1);
          if (lock_cnt_r == LOCK_LAST) begin
            state_s   = FINISH;
          end else if (wd_expired_s) begin
            timeout_s = 1'b1;
            state_s   = IDLE;
          end else begin
            state_s   = WAIT_LOCK;
          end
        end else begin
          lock_cnt_s = '0;
          if (wd_expired_s) begin
            timeout_s = 1'b1;
            state_s   = IDLE;
          end else begin
            state_s   = WAIT_LOCK;
          end
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      start_r    <= 1'b0;
      done_r     <= 1'b0;
      lock_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      ready_r    <= (state_s == IDLE);
      busy_r     <= (state_s != IDLE);
      start_r    <= (state_s == START);
      done_r     <= (state_s == FINISH);
      lock_cnt_r <= lock_cnt_s;
    end
  end

  // Request capture, sticky error, counter fields and last-applied divide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r        <= DIV_W'(DIVIDE_RESET);
      error_r      <= 1'b0;
      fields_r     <= RESET_FIELDS;
      cur_divide_r <= DIV_W'(DIVIDE_RESET);
    end else begin
      if (accept_s) begin
        div_r   <= req_divide;
        error_r <= 1'b0;
      end else if (reject_s || timeout_s) begin
        error_r <= 1'b1;
      end
      if (load_fields_s) begin
        fields_r <= enc_fields_s;
      end
      if (state_s == FINISH) begin
        cur_divide_r <= div_r;
      end
    end
  end

  assign req_ready         = ready_r;
  assign busy              = busy_r;
  assign start_reconfig    = start_r;
  assign done              = done_r;
  assign error             = error_r;
  assign cur_divide        = cur_divide_r;
  assign clkout0_high_time = fields_r.high_time;
  assign clkout0_low_time  = fields_r.low_time;
  assign clkout0_edge      = fields_r.edge_bit;
  assign clkout0_no_count  = fields_r.no_count;

endmodule
